// File: rtl/spi_slave_frame.sv
// spi_slave_frame: SPI slave front-end. Deserialises MOSI frames of DATA_W+2
// bits (2-bit command + payload) into rx_data and serialises read-back data
// onto MISO. Optional macro SPI_SLAVE_FRAME_ERR_EN adds the frame_err output.
module spi_slave_frame #(
  parameter int DATA_W    = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MOSI,
  input  logic              SS_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  output logic              MISO,
  output logic              busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);

  localparam int CW = $clog2(DATA_W + 3);
  localparam logic [CW-1:0] LAST_RX = CW'(DATA_W + 1);
  localparam logic [CW-1:0] TX_LAST = CW'(DATA_W);
  localparam logic [CW-1:0] CNT_MAX = CW'(DATA_W + 2);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
  typedef enum logic [1:0] {TX_WAIT, TX_SHIFT, TX_DONE} tx_phase_t;

  state_t            state_q, state_d;
  tx_phase_t         tx_phase_q, tx_phase_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W+1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W+1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_done_q, rx_done_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic              miso_q, miso_d;
  logic              rd_addr_seen_q, rd_addr_seen_d;

  logic [DATA_W+1:0] rx_shift;
  logic [DATA_W-1:0] tx_next;
  logic              tx_bit;
  logic [CW-1:0]     cnt_inc;

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic frame_err_q, frame_err_d;
  logic abort_err;
`endif

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      tx_phase_q     <= TX_WAIT;
      cnt_q          <= '0;
      rx_sr_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_done_q      <= 1'b0;
      tx_sr_q        <= '0;
      miso_q         <= 1'b0;
      rd_addr_seen_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      tx_phase_q     <= tx_phase_d;
      cnt_q          <= cnt_d;
      rx_sr_q        <= rx_sr_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_done_q      <= rx_done_d;
      tx_sr_q        <= tx_sr_d;
      miso_q         <= miso_d;
      rd_addr_seen_q <= rd_addr_seen_d;
    end
  end

  // Next-state and datapath logic; SS_n high overrides everything.
  always_comb begin
    state_d        = state_q;
    tx_phase_d     = tx_phase_q;
    cnt_d          = cnt_q;
    rx_sr_d        = rx_sr_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rx_done_d      = rx_done_q;
    tx_sr_d        = tx_sr_q;
    miso_d         = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;

    if (MSB_FIRST != 0) begin
      rx_shift = {rx_sr_q[DATA_W:0], MOSI};
      tx_bit   = tx_sr_q[DATA_W-1];
      tx_next  = tx_sr_q << 1;
    end else begin
      rx_shift = {MOSI, rx_sr_q[DATA_W+1:1]};
      tx_bit   = tx_sr_q[0];
      tx_next  = tx_sr_q >> 1;
    end
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    if (SS_n) begin
      state_d    = IDLE;
      tx_phase_d = TX_WAIT;
      cnt_d      = '0;
      rx_sr_d    = '0;
      tx_sr_d    = '0;
      rx_done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = CHK_CMD;
          cnt_d   = '0;
        end
        CHK_CMD: begin
          cnt_d = '0;
          if (!MOSI)               state_d = WRITE;
          else if (rd_addr_seen_q) state_d = READ_DATA;
          else                     state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (!rx_done_q) begin
            rx_sr_d = rx_shift;
            if (cnt_q == LAST_RX) begin
              rx_data_d  = rx_shift;
              rx_valid_d = 1'b1;
              rx_done_d  = 1'b1;
              cnt_d      = '0;
              if (state_q == READ_ADD) rd_addr_seen_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (state_q == READ_DATA) begin
            // The counter is reused to pace the DATA_W MISO bits; one extra
            // edge after the last bit returns MISO to 0.
            case (tx_phase_q)
              TX_WAIT: begin
                if (tx_valid) begin
                  tx_sr_d    = tx_data;
                  cnt_d      = '0;
                  tx_phase_d = TX_SHIFT;
                end
              end
              TX_SHIFT: begin
                if (cnt_q == TX_LAST) begin
                  tx_phase_d     = TX_DONE;
                  rd_addr_seen_d = 1'b0;
                end else begin
                  miso_d  = tx_bit;
                  tx_sr_d = tx_next;
                  cnt_d   = cnt_inc;
                end
              end
              default: ;
            endcase
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  // Abort detection: SS_n rising while a frame or read-back is unfinished.
  always_comb begin
    abort_err = 1'b0;
    case (state_q)
      CHK_CMD:         abort_err = 1'b1;
      WRITE, READ_ADD: abort_err = !rx_done_q;
      READ_DATA:       abort_err = (tx_phase_q != TX_DONE);
      default:         abort_err = 1'b0;
    endcase
    frame_err_d = SS_n && abort_err;
  end

  // Registered one-cycle abort pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err_q <= 1'b0;
    else        frame_err_q <= frame_err_d;
  end

  assign frame_err = frame_err_q;
`endif

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign MISO     = miso_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_frame.sv
// tb_spi_slave_frame: scoreboard bench for spi_slave_frame with two
// instances (DATA_W=8 MSB-first, DATA_W=16 LSB-first).
module tb_spi_slave_frame;

  localparam int S_MISO = 0;
  localparam int S_BUSY = 1;
  localparam int S_RXV  = 2;
  localparam int S_RXD  = 3;
  localparam int S_FERR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        mosi8, ss8, txv8, rxv8, miso8, busy8;
  logic [7:0]  txd8;
  logic [9:0]  rxd8;
  logic        mosi16, ss16, txv16, rxv16, miso16, busy16;
  logic [15:0] txd16;
  logic [17:0] rxd16;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic        ferr8, ferr16;
`endif

  spi_slave_frame #(.DATA_W(8), .MSB_FIRST(1)) u8 (
    .clk(clk), .rst_n(rst_n), .MOSI(mosi8), .SS_n(ss8),
    .tx_valid(txv8), .tx_data(txd8), .rx_data(rxd8), .rx_valid(rxv8),
    .MISO(miso8), .busy(busy8)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    , .frame_err(ferr8)
`endif
  );

  spi_slave_frame #(.DATA_W(16), .MSB_FIRST(0)) u16 (
    .clk(clk), .rst_n(rst_n), .MOSI(mosi16), .SS_n(ss16),
    .tx_valid(txv16), .tx_data(txd16), .rx_data(rxd16), .rx_valid(rxv16),
    .MISO(miso16), .busy(busy16)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    , .frame_err(ferr16)
`endif
  );

  typedef struct {
    int          cyc;
    int          d;
    int          sig;
    logic [31:0] v;
  } chk_t;

  chk_t        chkq[$];
  logic [31:0] exp_rx8[$];
  logic [31:0] exp_rx16[$];
  int          n_pass  = 0;
  int          n_total = 0;
  int          cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] probe(int d, int sig);
    logic [31:0] r;
    r = '0;
    case (sig)
      S_MISO: r = (d == 0) ? 32'(miso8) : 32'(miso16);
      S_BUSY: r = (d == 0) ? 32'(busy8) : 32'(busy16);
      S_RXV:  r = (d == 0) ? 32'(rxv8)  : 32'(rxv16);
      S_RXD:  r = (d == 0) ? 32'(rxd8)  : 32'(rxd16);
`ifdef SPI_SLAVE_FRAME_ERR_EN
      S_FERR: r = (d == 0) ? 32'(ferr8) : 32'(ferr16);
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic string signame(int sig);
    case (sig)
      S_MISO:  return "MISO";
      S_BUSY:  return "busy";
      S_RXV:   return "rx_valid";
      S_RXD:   return "rx_data";
      default: return "frame_err";
    endcase
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Monitor: pops expected frames on rx_valid and applies cycle-tagged checks.
  always @(negedge clk) begin
    if (rxv8 === 1'b1) begin
      if (exp_rx8.size() == 0) begin
        n_total++;
        $display("FAIL u8 unexpected rx_valid @%0d: rx_data 0x%0h, none expected", cyc, rxd8);
      end else check($sformatf("u8 rx frame @%0d", cyc), 32'(rxd8), exp_rx8.pop_front());
    end
    if (rxv16 === 1'b1) begin
      if (exp_rx16.size() == 0) begin
        n_total++;
        $display("FAIL u16 unexpected rx_valid @%0d: rx_data 0x%0h, none expected", cyc, rxd16);
      end else check($sformatf("u16 rx frame @%0d", cyc), 32'(rxd16), exp_rx16.pop_front());
    end
    for (int i = 0; i < chkq.size(); ) begin
      if (chkq[i].cyc <= cyc) begin
        check($sformatf("u%0d %s @%0d", (chkq[i].d == 0) ? 8 : 16, signame(chkq[i].sig), chkq[i].cyc),
              probe(chkq[i].d, chkq[i].sig), chkq[i].v);
        chkq.delete(i);
      end else i++;
    end
  end

  function automatic void expect_at(int c, int d, int sig, logic [31:0] v);
    chk_t e;
    e.cyc = c; e.d = d; e.sig = sig; e.v = v;
    chkq.push_back(e);
  endfunction

  function automatic void expect_ferr(int c, int d, logic v);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    expect_at(c, d, S_FERR, 32'(v));
`else
    if (v === 1'bx) $display("note: unknown frame_err request ignored (u%0d @%0d)", d, c);
`endif
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ss(int d, logic v);
    if (d == 0) ss8 = v; else ss16 = v;
  endtask

  task automatic set_mosi(int d, logic v);
    if (d == 0) mosi8 = v; else mosi16 = v;
  endtask

  task automatic set_tx(int d, logic v, logic [15:0] data);
    if (d == 0) begin txv8 = v; txd8 = data[7:0]; end
    else begin txv16 = v; txd16 = data; end
  endtask

  // SS_n low (IDLE->CHK_CMD edge), then the selector bit on the CHK_CMD edge.
  task automatic begin_frame(int d, logic sel);
    set_ss(d, 1'b0);
    set_mosi(d, 1'b0);
    next();
    expect_at(cyc, d, S_BUSY, 1);
    set_mosi(d, sel);
    next();
  endtask

  task automatic shift_bits(int d, logic [31:0] bits, int n, bit msb, int send_n, bit expect_rx);
    int idx;
    for (int i = 0; i < send_n; i++) begin
      idx = msb ? (n - 1 - i) : i;
      set_mosi(d, bits[idx]);
      if (expect_rx && i == n - 1) begin
        if (d == 0) exp_rx8.push_back(bits); else exp_rx16.push_back(bits);
        expect_at(cyc + 1, d, S_RXV, 1);
        expect_at(cyc + 1, d, S_RXD, bits);
        expect_at(cyc + 2, d, S_RXV, 0);
      end
      if (i == 2) expect_at(cyc + 1, d, S_MISO, 0);
      next();
    end
  endtask

  task automatic end_frame(int d, logic exp_err);
    set_ss(d, 1'b1);
    next();
    expect_at(cyc, d, S_BUSY, 0);
    expect_at(cyc, d, S_MISO, 0);
    expect_ferr(cyc, d, exp_err);
    expect_ferr(cyc + 1, d, 1'b0);
    next();
  endtask

  // Frame with a read-back: checks MISO for each edge after tx_data capture.
  task automatic read_back(int d, logic [15:0] data, int w, bit msb);
    int c;
    int idx;
    set_tx(d, 1'b1, data);
    next();
    c = cyc;
    set_tx(d, 1'b0, 16'h0000);
    expect_at(c, d, S_MISO, 0);
    for (int k = 1; k <= w; k++) begin
      idx = msb ? (w - k) : (k - 1);
      expect_at(c + k, d, S_MISO, 32'(data[idx]));
    end
    expect_at(c + w + 1, d, S_MISO, 0);
    for (int k = 1; k <= w + 1; k++) begin
      // tx_valid outside the wait phase must be ignored
      if (k == 3) set_tx(d, 1'b1, 16'hFFFF);
      if (k == 4) set_tx(d, 1'b0, 16'h0000);
      next();
    end
  endtask

  // tx_valid offered after a READ_ADD frame must not start a transfer.
  task automatic expect_no_tx(int d);
    set_tx(d, 1'b1, 16'hFFFF);
    for (int k = 1; k <= 3; k++) expect_at(cyc + k, d, S_MISO, 0);
    next(); next(); next();
    set_tx(d, 1'b0, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ss8 = 1'b1; mosi8 = 1'b0; txv8 = 1'b0; txd8 = '0;
    ss16 = 1'b1; mosi16 = 1'b0; txv16 = 1'b0; txd16 = '0;
    next(); next();
    for (int d = 0; d < 2; d++) begin
      expect_at(cyc, d, S_RXD, 0);
      expect_at(cyc, d, S_RXV, 0);
      expect_at(cyc, d, S_MISO, 0);
      expect_at(cyc, d, S_BUSY, 0);
      expect_ferr(cyc, d, 1'b0);
    end
    next();
    rst_n = 1'b1;
    next();

    // Write frame 00_1010_0101, extra edge with MOSI high is ignored
    begin_frame(0, 1'b0);
    shift_bits(0, 32'h0A5, 10, 1'b1, 10, 1'b1);
    set_mosi(0, 1'b1);
    expect_at(cyc + 1, 0, S_BUSY, 1);
    next();
    end_frame(0, 1'b0);

    // Read address, then read data with tx_data=0x3C two cycles after rx_valid
    begin_frame(0, 1'b1);
    shift_bits(0, 32'h203, 10, 1'b1, 10, 1'b1);
    end_frame(0, 1'b0);
    begin_frame(0, 1'b1);
    shift_bits(0, 32'h300, 10, 1'b1, 10, 1'b1);
    next();
    read_back(0, 16'h003C, 8, 1'b1);
    end_frame(0, 1'b0);

    // rd_addr_seen cleared: selector 1 is a READ_ADD frame again
    begin_frame(0, 1'b1);
    shift_bits(0, 32'h207, 10, 1'b1, 10, 1'b1);
    expect_no_tx(0);
    end_frame(0, 1'b0);

    // Reset during a 0xFF MISO transfer
    begin_frame(0, 1'b1);
    shift_bits(0, 32'h3FF, 10, 1'b1, 10, 1'b1);
    set_tx(0, 1'b1, 16'h00FF);
    next();
    set_tx(0, 1'b0, 16'h0000);
    expect_at(cyc + 1, 0, S_MISO, 1);
    next(); next();
    expect_at(cyc, 0, S_MISO, 0);
    expect_at(cyc, 0, S_BUSY, 0);
    expect_at(cyc, 0, S_RXV, 0);
    rst_n = 1'b0;
    set_ss(0, 1'b1);
    next();
    rst_n = 1'b1;
    next();
    begin_frame(0, 1'b1);
    shift_bits(0, 32'h211, 10, 1'b1, 10, 1'b1);
    expect_no_tx(0);
    end_frame(0, 1'b0);

    // Abort after 5 payload bits: rx_data keeps 0x211
    begin_frame(0, 1'b0);
    shift_bits(0, 32'h155, 10, 1'b1, 5, 1'b0);
    end_frame(0, 1'b1);
    expect_at(cyc, 0, S_RXD, 32'h211);

    // Abort mid read-back keeps rd_addr_seen: next selector 1 is READ_DATA
    begin_frame(0, 1'b1);
    shift_bits(0, 32'h3AA, 10, 1'b1, 10, 1'b1);
    set_tx(0, 1'b1, 16'h00A5);
    next();
    set_tx(0, 1'b0, 16'h0000);
    next(); next();
    end_frame(0, 1'b1);
    begin_frame(0, 1'b1);
    shift_bits(0, 32'h3AB, 10, 1'b1, 10, 1'b1);
    set_tx(0, 1'b1, 16'h0080);
    next();
    set_tx(0, 1'b0, 16'h0000);
    expect_at(cyc + 1, 0, S_MISO, 1);
    expect_at(cyc + 2, 0, S_MISO, 0);
    next(); next();
    end_frame(0, 1'b1);

    // SS_n rises on the edge of the final receive bit
    begin_frame(0, 1'b0);
    shift_bits(0, 32'h3C3, 10, 1'b1, 9, 1'b0);
    set_mosi(0, 1'b1);
    end_frame(0, 1'b1);
    expect_at(cyc, 0, S_RXD, 32'h3AB);

    // 16-bit LSB-first instance
    begin_frame(1, 1'b0);
    shift_bits(1, 32'h2BEEF, 18, 1'b0, 18, 1'b1);
    end_frame(1, 1'b0);
    begin_frame(1, 1'b1);
    shift_bits(1, 32'h20005, 18, 1'b0, 18, 1'b1);
    end_frame(1, 1'b0);
    begin_frame(1, 1'b1);
    shift_bits(1, 32'h30000, 18, 1'b0, 18, 1'b1);
    read_back(1, 16'h8001, 16, 1'b0);
    end_frame(1, 1'b0);

    next(); next();
    if (exp_rx8.size() != 0 || exp_rx16.size() != 0) begin
      n_total++;
      $display("FAIL pending rx frames: got %0d left, expected 0", exp_rx8.size() + exp_rx16.size());
    end
    if (chkq.size() != 0) begin
      n_total++;
      $display("FAIL pending checks: got %0d left, expected 0", chkq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
